// File: rtl/mc_delay_line.sv
// Multi-channel programmable sample delay line: NUM_CH streams share one circular
// buffer and one write pointer; output is the sample accepted D valid samples earlier.
module mc_delay_line #(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in,
  input  logic                         cfg_load,
  input  logic [$clog2(MAX_DELAY):0]   delay_cfg,
  output logic [NUM_CH*DATA_WIDTH-1:0] out,
  output logic                         out_valid,
  output logic                         switch_enable
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam int W  = NUM_CH * DATA_WIDTH;

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam cnt_t MAX_D   = cnt_t'(MAX_DELAY);
  localparam cnt_t DEF_D   = cnt_t'(DEFAULT_DELAY);
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [W-1:0] r_mem [MAX_DELAY];
  ptr_t         r_wrPtr;
  cnt_t         r_delay;
  cnt_t         r_fill;
  cnt_t         r_blkCnt;

  cnt_t         w_cfgDelay;
  cnt_t         w_delay;
  cnt_t         w_fill;
  cnt_t         w_blkCnt;
  ptr_t         w_rdAddr;
  logic         w_outValid;

  // A cfg_load takes effect on the sample arriving in the same cycle, so the
  // effective delay/fill/block count are muxed here rather than taken from registers.
  always_comb begin
    w_cfgDelay = delay_cfg;
    if (delay_cfg == '0) begin
      w_cfgDelay = CNT_ONE;
    end else if (delay_cfg > MAX_D) begin
      w_cfgDelay = MAX_D;
    end
    w_delay    = cfg_load ? w_cfgDelay : r_delay;
    w_fill     = cfg_load ? '0 : r_fill;
    w_blkCnt   = cfg_load ? '0 : r_blkCnt;
    w_rdAddr   = r_wrPtr - w_delay[AW-1:0];
    w_outValid = in_valid && (w_fill >= w_delay);
  end

  always_ff @(posedge clk) begin
    if (in_valid && !reset) begin
      r_mem[r_wrPtr] <= in;
    end
  end

  // The buffer read below sees the pre-write contents, which is what makes D==MAX_DELAY
  // (read and write at the same address) return the oldest sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr       <= '0;
      r_delay       <= DEF_D;
      r_fill        <= '0;
      r_blkCnt      <= '0;
      out           <= '0;
      out_valid     <= 1'b0;
      switch_enable <= 1'b0;
    end else begin
      r_delay       <= w_delay;
      r_fill        <= w_fill;
      r_blkCnt      <= w_blkCnt;
      out_valid     <= w_outValid;
      switch_enable <= w_outValid && (w_blkCnt == '0);
      if (in_valid) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
        out     <= r_mem[w_rdAddr];
        if (w_fill < w_delay) begin
          r_fill <= w_fill + CNT_ONE;
        end
        if (w_outValid) begin
          r_blkCnt <= (w_blkCnt == w_delay - CNT_ONE) ? '0 : w_blkCnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_delay_line.sv
// Randomised self-checking bench for mc_delay_line against a sample-history reference
// model: valid output = the sample accepted D samples ago, counted since the last reset/reload.
module tb_mc_delay_line;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int MAXD   = 64;
  localparam int W      = NUM_CH * DW;

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic [W-1:0] inData;
  logic         cfgLoad;
  logic [6:0]   delayCfg;
  logic [W-1:0] outData;
  logic         outValid;
  logic         switchEnable;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  logic [W-1:0] hist[$];
  int           modelD;
  int           acceptedCnt;
  int           validCnt;
  logic         expValid;
  logic         expSwitch;
  logic [W-1:0] expOut;
  logic         outKnown;

  mc_delay_line #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_DELAY(MAXD), .DEFAULT_DELAY(MAXD)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(inData),
    .cfg_load(cfgLoad), .delay_cfg(delayCfg),
    .out(outData), .out_valid(outValid), .switch_enable(switchEnable)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  // Drives one cycle, advances the reference model, then checks the registered outputs.
  task automatic applyStimulus(input logic rst, input logic vld, input logic cfg,
                               input logic [6:0] cfgVal, input logic [W-1:0] data);
    @(negedge clk);
    reset    = rst;
    inValid  = vld;
    cfgLoad  = cfg;
    delayCfg = cfgVal;
    inData   = data;
    if (rst) begin
      modelD      = MAXD;
      acceptedCnt = 0;
      validCnt    = 0;
      expValid    = 1'b0;
      expSwitch   = 1'b0;
      expOut      = '0;
      outKnown    = 1'b1;
    end else begin
      if (cfg) begin
        modelD      = (cfgVal == 0) ? 1 : ((int'(cfgVal) > MAXD) ? MAXD : int'(cfgVal));
        acceptedCnt = 0;
        validCnt    = 0;
      end
      if (vld) begin
        expValid  = (acceptedCnt >= modelD);
        expSwitch = expValid && ((validCnt % modelD) == 0);
        outKnown  = expValid;
        if (expValid) begin
          expOut = hist[hist.size() - modelD];
          validCnt++;
        end
        acceptedCnt++;
        hist.push_back(data);
      end else begin
        expValid  = 1'b0;
        expSwitch = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", W'(outValid), W'(expValid));
    checkOutput("switch_enable", W'(switchEnable), W'(expSwitch));
    if (outKnown) begin
      checkOutput("out", outData, expOut);
    end
  endtask

  function automatic logic [W-1:0] rampWord(input int i);
    logic [W-1:0] d;
    d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      d[c*DW +: DW] = DW'(16 * c + i);
    end
    return d;
  endfunction

  function automatic logic [W-1:0] randWord();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b0; inValid = 1'b0; cfgLoad = 1'b0; delayCfg = '0; inData = '0;

    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("reset_out", outData, '0);

    // Default ramp, D=64
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(0, 1, 0, 0, rampWord(i));
      if (i == 64) begin
        checkOutput("ramp_first_ch0", W'(outData[0 +: DW]), W'(0));
        checkOutput("ramp_first_ch3", W'(outData[3*DW +: DW]), W'(48));
        checkOutput("ramp_first_sw", W'(switchEnable), W'(1));
      end
    end

    // Gapped input with D=8, pattern 1,0,0,1
    applyStimulus(0, 0, 1, 8, '0);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, ((i % 4) == 0) || ((i % 4) == 3), 0, 0, randWord());
    end

    // Reprogram to 5 on sample 200 of a stream, then reset at sample 300
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1, i == 200, 5, rampWord(i));
    end
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("midreset_out", outData, '0);
    for (int i = 0; i < 150; i++) begin
      applyStimulus(0, 1, 0, 0, rampWord(i + 2000));
    end

    // delay_cfg=0 behaves as D=1
    applyStimulus(0, 0, 1, 0, '0);
    for (int i = 0; i < 50; i++) applyStimulus(0, 1, 0, 0, randWord());

    // delay_cfg=100 clamps to 64; long enough to wrap the pointer several times
    applyStimulus(0, 0, 1, 100, '0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 0, 0, randWord());

    // cfg_load together with in_valid, D=3
    applyStimulus(0, 1, 1, 3, randWord());
    for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 0, randWord());

    // reset and cfg_load together: reset wins, D back to 64
    applyStimulus(1, 1, 1, 3, randWord());
    for (int i = 0; i < 80; i++) applyStimulus(0, 1, 0, 0, randWord());

    // Randomised mix of gaps, reloads and resets
    for (int i = 0; i < 4000; i++) begin
      logic rst, vld, cfg;
      rst = ($urandom_range(0, 999) == 0);
      cfg = ($urandom_range(0, 149) == 0);
      vld = ($urandom_range(0, 9) < 7);
      applyStimulus(rst, vld, cfg, 7'($urandom_range(0, 127)), randWord());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
